counter_load_arbiter: RTL
=========================

# counter_load_arbiter

Round-robin scheduler that shares one 4-bit loadable up-counter (load strobe plus load value, free-running count-up) among NUM_REQ requesters. It sits directly in front of the counter. It arbitrates load requests, drives the counter's load strobe and value for one cycle, and watches the count until terminal (all ones). It then reports completion to the owning requester and releases the counter for the next grant.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- CNT_W, 4: counter width.
- TIMEOUT, 32: RUN-state watchdog limit in cycles (used only with the watchdog compiled in).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester load request, level.
- load_val_i  in  NUM_REQ*CNT_W  per-requester load value; requester r occupies bits [r*CNT_W +: CNT_W].
- gnt_o  out  NUM_REQ  one-cycle grant pulse, one-hot.
- done_o  out  NUM_REQ  one-cycle completion pulse to the owner.
- busy_o  out  1  high whenever state is not IDLE.
- owner_o  out  $clog2(NUM_REQ)  index of the current or last owner.
- load_o  out  1  counter load strobe.
- load_val_o  out  CNT_W  counter load value.
- cnt_i  in  CNT_W  counter's current count.
- timeout_o  out  1  one-cycle watchdog pulse.

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- IDLE:
  - When any req_i bit is high, select winner w by round robin, starting the search at pointer ptr.
  - Register w into owner_o and load_val_i[w] into load_val_o, then go to LOAD.
  - When no request is present, stay in IDLE.
- LOAD (exactly 1 cycle): load_o=1 and gnt_o[w]=1, then go to RUN. ptr updates to (w+1) mod NUM_REQ.
- RUN: when cnt_i == all ones, go to DONE. req_i is ignored in RUN, including the owner's.
- DONE (exactly 1 cycle): done_o[owner]=1, then go to IDLE.
- Requester rules:
  - A requester holds req_i until it sees gnt_o.
  - A requester that drops req_i before grant loses its turn without error.
  - load_val_i is sampled only in the IDLE winning cycle.
- Loaded value all ones: the first RUN cycle sees terminal and goes straight to DONE.
- Requests arriving during LOAD, RUN or DONE wait and are arbitrated in the next IDLE cycle.
- Reset asserted at any point, including mid-RUN:
  - State returns to IDLE and ptr to 0.
  - All outputs go to 0: gnt_o, done_o, busy_o, owner_o, load_o, load_val_o, timeout_o.
  - No done_o pulse is issued for the aborted run.

## Timing
- Request seen in IDLE at cycle T: load_o and gnt_o at T+1; first RUN cycle at T+2, when cnt_i shows the loaded value.
- Loaded value v: RUN lasts (2^CNT_W - 1 - v) + 1 cycles. Example: v=0xA gives 6 RUN cycles.
- done_o fires the cycle after terminal is observed. The earliest next grant comes 2 cycles after done_o (IDLE arbitration, then LOAD).
- load_o, load_val_o and gnt_o are registered outputs. done_o and busy_o decode directly from state registers.

## Configuration
- Macro: COUNTER_LOAD_ARBITER_WATCHDOG_EN.
- Defined:
  - An internal counter clears on entry to RUN and increments each RUN cycle.
  - If TIMEOUT cycles pass in RUN without terminal, the block pulses timeout_o for 1 cycle and returns to IDLE.
  - No done_o pulse is issued for a timed-out run.
  - Terminal on the same cycle the count reaches TIMEOUT counts as normal completion: DONE, no timeout.
- Undefined: timeout_o is tied to 0, there is no watchdog counter, and RUN waits indefinitely.

## Structure
- Package counter_load_pkg holds:
  - State enum: IDLE, LOAD, RUN, DONE.
  - Terminal-count constant: all ones of CNT_W.
  - Default TIMEOUT.
- Sub-module rr_arbiter: combinational round-robin pick from req vector and ptr, giving a one-hot grant and an index.

## Test plan
- Single request: req_i=4'b0001, load_val_i[0]=0xA. Expect load_o and gnt_o[0] one cycle after the request, 6 RUN cycles, then done_o[0], then busy_o=0.
- Contention: req_i=4'b1111 held after reset. Expect grants in order 0,1,2,3,0, each separated by a full RUN/DONE window.
- Edge values:
  - load_val 0xF: expect exactly 1 RUN cycle before done_o.
  - load_val 0x0: expect 16 RUN cycles.
- Late request: req_i[2] rises while requester 1 is in RUN. Expect gnt_o[2] exactly 2 cycles after done_o[1].
- Reset mid-RUN: drive reset=0 for 1 cycle. Expect all outputs at 0 immediately, no done_o, and the next grant going to requester 0.
- Watchdog (macro defined, TIMEOUT=8): hold cnt_i constant at 0x3. Expect timeout_o after 8 RUN cycles, no done_o, and return to IDLE.

Source files
------------

// File: rtl/counter_load_arbiter_pkg.sv
// Shared state encoding and constants for the counter load arbiter.
// The package name is counter_load_pkg; it is imported by the interface, the arbiter top and its sub-module.
package counter_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_CNT_W   = 4;
    localparam int DEFAULT_TIMEOUT = 32;

    // Terminal count is all ones; users slice the low CNT_W bits.
    localparam logic [31:0] TERM_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/counter_load_arbiter_if.sv
// Requester/counter-facing bundle of the counter load arbiter.
// The arbiter connects through the slave modport; the requesters and the counter use the master modport.
interface counter_load_arbiter_if
    import counter_load_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int CNT_W   = DEFAULT_CNT_W
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*CNT_W-1:0] load_val_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;
    logic [IDX_W-1:0]         owner_o;
    logic                     load_o;
    logic [CNT_W-1:0]         load_val_o;
    logic [CNT_W-1:0]         cnt_i;
    logic                     timeout_o;

    modport slave (
        input  req_i, load_val_i, cnt_i,
        output gnt_o, done_o, busy_o, owner_o, load_o, load_val_o, timeout_o
    );

    modport master (
        output req_i, load_val_i, cnt_i,
        input  gnt_o, done_o, busy_o, owner_o, load_o, load_val_o, timeout_o
    );

endinterface

// File: rtl/counter_load_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps, yielding a one-hot grant and its index.
module rr_arbiter
    import counter_load_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/counter_load_arbiter.sv
// Round-robin owner of a shared loadable up-counter: grant, load for one cycle, wait for terminal, report done.
// Optional RUN-state watchdog compiled in with COUNTER_LOAD_ARBITER_WATCHDOG_EN.
module counter_load_arbiter
    import counter_load_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input logic                    clk,
    input logic                    reset,
    counter_load_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOAD = LOAD;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [CNT_W-1:0] TERM_CNT = TERM_ALL_ONES[CNT_W-1:0];

    // Out-of-range configurations never grant.
    localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TIMEOUT >= 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] gnt_q;
    logic               load_q;
    logic [CNT_W-1:0]   load_val_q;
    logic [NUM_REQ-1:0] done_vec;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic               run_term;
    logic               wd_fire;

    assign arb_req  = CFG_OK ? bus.req_i : '0;
    assign run_term = (bus.cnt_i == TERM_CNT);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (arb_req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            gnt_q      <= '0;
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else begin
            gnt_q  <= '0;
            load_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        owner      <= arb_idx;
                        load_val_q <= bus.load_val_i[int'(arb_idx)*CNT_W +: CNT_W];
                        gnt_q      <= arb_gnt;
                        load_q     <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ptr   <= (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // Terminal takes priority over a watchdog expiry in the same cycle.
                    if (run_term) begin
                        state <= S_DONE;
                    end else if (wd_fire) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COUNTER_LOAD_ARBITER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT+1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_fire = (wd_cnt == WD_W'(TIMEOUT-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == S_RUN) && !run_term && wd_fire;
            if (state == S_LOAD) begin
                wd_cnt <= '0;
            end else if ((state == S_RUN) && !wd_fire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign wd_fire       = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_comb begin
        done_vec = '0;
        if (state == S_DONE) begin
            done_vec[owner] = 1'b1;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.load_o     = load_q;
    assign bus.load_val_o = load_val_q;
    assign bus.owner_o    = owner;
    assign bus.done_o     = done_vec;
    assign bus.busy_o     = (state != S_IDLE);

endmodule
